// File: rtl/area_downscaler_pkg.sv
// Shared types and width helpers for the area downscaler.
// State encoding, accumulator sizing and channel slicing.
package area_downscaler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int log2f(input int f);
    return $clog2(f);
  endfunction

  // Per-channel accumulator width: holds FACTOR*FACTOR pixel sum.
  function automatic int acc_w(input int dw, input int f);
    return dw + 2 * $clog2(f);
  endfunction

  function automatic int ch_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/line_acc_ram.sv
// Line accumulator storage: one partial column-sum set per output column.
// Ports: clk, we, addr, wdata; rdata is a combinational read of addr.
module line_acc_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 36,
  parameter int IW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/area_downscaler.sv
// Streaming box-filter downscaler: rounded mean of each FACTOR^2 block.
// Ports: clk, rst (async low), start, in_* / out_* valid-ready, complete.
module area_downscaler
  import area_downscaler_pkg::*;
#(
  parameter int H_IN    = 1024,
  parameter int W_IN    = 1024,
  parameter int FACTOR  = 4,
  parameter int CHANNEL = 3,
  parameter int DW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHANNEL*DW-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHANNEL*DW-1:0] out_data,
  output logic                  out_last,
  output logic                  complete
);

  localparam int LOG2F = log2f(FACTOR);
  localparam int AW    = acc_w(DW, FACTOR);
  localparam int SH    = 2 * LOG2F;
  localparam int XW    = $clog2(W_IN);
  localparam int YW    = $clog2(H_IN);
  localparam int DEPTH = W_IN / FACTOR;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = CHANNEL * AW;
  localparam logic [AW-1:0] HALF = AW'(1) << (SH - 1);

  state_e state;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic          all_in;
  logic [LW-1:0] hacc;
  logic [LW-1:0] hsum;
  logic [LW-1:0] rd;
  logic [LW-1:0] wd;
  logic [CHANNEL*DW-1:0] avg;
  logic [LOG2F-1:0] xm;
  logic [LOG2F-1:0] ym;
  logic [IW-1:0] idx;
  logic fire, x_end, y_end, blk_x, blk_y, emit;

  assign xm    = x_in[LOG2F-1:0];
  assign ym    = y_in[LOG2F-1:0];
  assign idx   = IW'(x_in >> LOG2F);
  assign x_end = (x_in == XW'(W_IN - 1));
  assign y_end = (y_in == YW'(H_IN - 1));
  assign blk_x = (xm == '1);
  assign blk_y = (ym == '1);

  // all_in stops intake once the frame's last pixel is in.
  assign in_ready = (state == RUN) & ~all_in
                  & (~out_valid | out_ready);
  assign fire = in_valid & in_ready;
  assign emit = fire & blk_x & blk_y;

  for (genvar c = 0; c < CHANNEL; c++) begin : g_ch
    localparam int AL = ch_lsb(c, AW);
    localparam int DL = ch_lsb(c, DW);
    logic [AW-1:0] px, hs, tot, rnd;
    assign px  = AW'(in_data[DL +: DW]);
    assign hs  = (xm == '0) ? px : hacc[AL +: AW] + px;
    assign tot = rd[AL +: AW] + hs;
    assign rnd = tot + HALF;
    assign hsum[AL +: AW] = hs;
    // First row of a block band overwrites stale line contents.
    assign wd[AL +: AW]   = (ym == '0) ? hs : tot;
    assign avg[DL +: DW]  = rnd[SH +: DW];
  end

  line_acc_ram #(
    .DEPTH(DEPTH),
    .WIDTH(LW),
    .IW   (IW)
  ) u_line (
    .clk  (clk),
    .we   (fire & blk_x),
    .addr (idx),
    .wdata(wd),
    .rdata(rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x_in      <= '0;
      y_in      <= '0;
      all_in    <= 1'b0;
      hacc      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      complete  <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (fire) begin
        hacc <= hsum;
        x_in <= x_end ? '0 : x_in + XW'(1);
        if (x_end) y_in <= y_end ? '0 : y_in + YW'(1);
        if (x_end & y_end) all_in <= 1'b1;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= avg;
        out_last  <= x_end & y_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      unique case (state)
        IDLE: if (start) begin
          state  <= RUN;
          x_in   <= '0;
          y_in   <= '0;
          all_in <= 1'b0;
        end
        RUN: if (out_valid & out_ready & out_last) begin
          state    <= DONE;
          complete <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/area_downscaler.md
Name: area_downscaler

Overview:
- Streaming box-filter (area-average) downscaler; the inverse direction of the bilinear upscaler top.
- Consumes a raster-order RGB frame of H_IN x W_IN pixels.
- Emits the H_IN/FACTOR x W_IN/FACTOR frame, where each output pixel is the rounded mean of its FACTOR x FACTOR input block.
- Used to shrink upscaled frames back for round-trip checking, and as a standalone decimator.

Parameters:
- H_IN, 1024, input frame height in pixels.
- W_IN, 1024, input frame width in pixels.
- FACTOR, 4, decimation factor per axis. Power of two, 2..16. H_IN and W_IN must be multiples of it.
- CHANNEL, 3, colour channels per pixel.
- DW, 8, bits per channel.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when the block is IDLE.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_data  in  CHANNEL*DW  pixel; channel 0 in the LSBs.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_data  out  CHANNEL*DW  averaged pixel; channel 0 in the LSBs.
- out_last  out  1  high with the final output pixel of the frame.
- complete  out  1  one-cycle pulse when the frame is finished.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, complete=0; state=IDLE; all counters 0.
- Handshakes: a transfer occurs on a rising edge where valid&ready are both high. out_data and out_last hold stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready = RUN & (~out_valid | out_ready).
  - DONE: complete=1 for exactly one cycle, then -> IDLE.
- RUN -> DONE on the cycle the out_last pixel is accepted.
- start outside IDLE is ignored.
- Counters: x_in counts 0..W_IN-1 and wraps to 0 with y_in++. y_in counts 0..H_IN-1. Both advance only on input transfers.
- LOG2F = log2(FACTOR). Accumulator width per channel AW = DW + 2*LOG2F; no overflow is possible.
- Horizontal accumulator hacc, per channel:
  - on x_in%FACTOR==0, hacc = pixel;
  - otherwise hacc += pixel.
- Line buffer: W_IN/FACTOR entries x CHANNEL x AW. On x_in%FACTOR==FACTOR-1, with idx = x_in>>LOG2F:
  - if y_in%FACTOR==0: line[idx] = hacc+pixel;
  - otherwise: line[idx] += hacc+pixel.
- Output: when x_in%FACTOR==FACTOR-1 and y_in%FACTOR==FACTOR-1, sum = line[idx]+hacc+pixel. On the next edge, out_data per channel = (sum + 2^(2*LOG2F-1)) >> (2*LOG2F), and out_valid=1.
  - Round half up. The result always fits in DW bits.
- Latency: first out_valid one cycle after the input transfer that completes a block.
- out_last=1 on the output produced from pixel (W_IN-1, H_IN-1).
- Simultaneous events: output accepted and new input accepted in the same cycle is legal. Full throughput is one pixel per cycle with out_ready held high.
- The line buffer is never explicitly cleared; row y%FACTOR==0 overwrites it.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). A fresh start is required; no stale output is emitted.
- in_valid while IDLE or DONE: not accepted (in_ready=0), no effect.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE), LOG2F/AW width functions, channel slice helper.
- One sub-module, line_acc_ram: W_IN/FACTOR-deep, CHANNEL*AW-wide, single-port read-modify-write. Combinational read, synchronous write; maps to distributed RAM.

Test Plan:
- Constant frame (8x8, FACTOR=4, CHANNEL=1), all pixels 100 -> 4 outputs of 100. out_last on the 4th. complete pulses once, 1 cycle after.
- Ramp (8x8, FACTOR=4), pixel = x+8*y -> block (0,0) sum 216 gives 14; block (1,0) gives 18; block (0,1) gives 46; block (1,1) gives 50.
- Rounding, one block: fifteen 0s and one 8 -> 1. Fifteen 0s and one 7 -> 0. All 255 -> 255 (no overflow).
- Backpressure: out_ready=0 for 10 cycles after the first out_valid -> in_ready=0 and out_data stable throughout. Releasing it resumes with no lost or duplicated pixel; the total output count is 4.
- Channels: CHANNEL=3, R=10, G=200, B=255 constant -> every out_data = {255,200,10}, with no cross-channel leakage.
- Reset mid-frame: assert rst after 20 input pixels -> all outputs go to 0 that cycle. After start, a full constant-50 frame yields only 50s and exactly 4 outputs.
